// File: rtl/pipeline_ctrl_if.sv
// Handshake bundle between the LoongArch pipeline stages and the stall/flush controller.
// Optional STALL_PERF_EN adds the performance counter outputs.
interface pipeline_ctrl_if #(
    parameter int PC_WIDTH       = 32,
    parameter int REG_ADDR_WIDTH = 5
);
    logic                      id_reg1_read_en_i;
    logic [REG_ADDR_WIDTH-1:0] id_reg1_read_addr_i;
    logic                      id_reg2_read_en_i;
    logic [REG_ADDR_WIDTH-1:0] id_reg2_read_addr_i;
    logic                      ex_is_load_i;
    logic                      ex_reg_write_en_i;
    logic [REG_ADDR_WIDTH-1:0] ex_reg_write_addr_i;
    logic                      ex_mc_start_i;
    logic                      ex_mc_done_i;
    logic                      flush_req_i;
    logic [PC_WIDTH-1:0]       flush_pc_i;
    logic [5:0]                stall_o;
    logic                      flush_o;
    logic [PC_WIDTH-1:0]       new_pc_o;
    logic                      mc_timeout_o;
`ifdef STALL_PERF_EN
    logic [31:0]               perf_stall_cycles_o;
    logic [31:0]               perf_flush_cnt_o;
`endif

    modport master (
        output id_reg1_read_en_i, id_reg1_read_addr_i, id_reg2_read_en_i, id_reg2_read_addr_i,
        output ex_is_load_i, ex_reg_write_en_i, ex_reg_write_addr_i, ex_mc_start_i, ex_mc_done_i,
        output flush_req_i, flush_pc_i,
        input  stall_o, flush_o, new_pc_o, mc_timeout_o
`ifdef STALL_PERF_EN
        , input perf_stall_cycles_o, perf_flush_cnt_o
`endif
    );

    modport slave (
        input  id_reg1_read_en_i, id_reg1_read_addr_i, id_reg2_read_en_i, id_reg2_read_addr_i,
        input  ex_is_load_i, ex_reg_write_en_i, ex_reg_write_addr_i, ex_mc_start_i, ex_mc_done_i,
        input  flush_req_i, flush_pc_i,
        output stall_o, flush_o, new_pc_o, mc_timeout_o
`ifdef STALL_PERF_EN
        , output perf_stall_cycles_o, perf_flush_cnt_o
`endif
    );
endinterface

// File: rtl/pipeline_ctrl.sv
// Stall/flush controller: load-use bubbles, multi-cycle ex sequencing with watchdog, redirect flushes.
// Define STALL_PERF_EN to add saturating stall-cycle and flush-pulse counters.
//
// state     | meaning
// ----------+--------------------------------------------------------------
// IDLE      | normal flow; only load-use hazards stall (pc/if/id)
// MC_BUSY   | multi-cycle ex op in flight; pc..ex held until done/flush/timeout
// FLUSH     | flush_o high for one cycle with new_pc_o; relatched on repeat req
module pipeline_ctrl #(
    parameter int PC_WIDTH       = 32,
    parameter int REG_ADDR_WIDTH = 5,
    parameter int MC_MAX_CYCLES  = 64,
    parameter int MC_CNT_WIDTH   = 7
) (
    input logic             clk,
    input logic             rst,
    pipeline_ctrl_if.slave  bus
);
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_MC_BUSY = 2'd1,
        ST_FLUSH   = 2'd2
    } state_t;

    localparam logic [MC_CNT_WIDTH-1:0] MC_LAST = MC_CNT_WIDTH'(MC_MAX_CYCLES - 1);

    state_t                  state;
    logic [MC_CNT_WIDTH-1:0] mc_cnt;
    logic                    flush_q;
    logic                    timeout_q;
    logic [PC_WIDTH-1:0]     new_pc_q;
    logic [5:0]              stall;
    logic                    hit1;
    logic                    hit2;
    logic                    load_use;

    assign hit1     = bus.id_reg1_read_en_i && (bus.id_reg1_read_addr_i == bus.ex_reg_write_addr_i);
    assign hit2     = bus.id_reg2_read_en_i && (bus.id_reg2_read_addr_i == bus.ex_reg_write_addr_i);
    assign load_use = bus.ex_is_load_i && bus.ex_reg_write_en_i &&
                      (bus.ex_reg_write_addr_i != '0) && (hit1 || hit2);

    // Stall drops in the completion/redirect cycle itself so no extra bubble is inserted.
    always_comb begin
        stall = 6'b000000;
        case (state)
            ST_IDLE:    if (load_use && !bus.flush_req_i)              stall = 6'b000111;
            ST_MC_BUSY: if (!bus.ex_mc_done_i && !bus.flush_req_i)     stall = 6'b001111;
            default:    stall = 6'b000000;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= ST_IDLE;
            mc_cnt    <= '0;
            flush_q   <= 1'b0;
            timeout_q <= 1'b0;
            new_pc_q  <= '0;
        end else begin
            flush_q   <= 1'b0;
            timeout_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (bus.flush_req_i) begin
                        state    <= ST_FLUSH;
                        flush_q  <= 1'b1;
                        new_pc_q <= bus.flush_pc_i;
                    end else if (bus.ex_mc_start_i) begin
                        state  <= ST_MC_BUSY;
                        mc_cnt <= MC_CNT_WIDTH'(1);
                    end
                end
                ST_MC_BUSY: begin
                    if (bus.flush_req_i) begin
                        state    <= ST_FLUSH;
                        flush_q  <= 1'b1;
                        new_pc_q <= bus.flush_pc_i;
                        mc_cnt   <= '0;
                    end else if (bus.ex_mc_done_i) begin
                        state  <= ST_IDLE;
                        mc_cnt <= '0;
                    end else if (mc_cnt == MC_LAST) begin
                        state     <= ST_IDLE;
                        mc_cnt    <= '0;
                        timeout_q <= 1'b1;
                    end else begin
                        mc_cnt <= mc_cnt + 1'b1;
                    end
                end
                ST_FLUSH: begin
                    if (bus.flush_req_i) begin
                        flush_q  <= 1'b1;
                        new_pc_q <= bus.flush_pc_i;
                    end else begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.stall_o      = stall;
    assign bus.flush_o      = flush_q;
    assign bus.new_pc_o     = new_pc_q;
    assign bus.mc_timeout_o = timeout_q;

`ifdef STALL_PERF_EN
    logic [31:0] perf_stall_q;
    logic [31:0] perf_flush_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_stall_q <= '0;
            perf_flush_q <= '0;
        end else begin
            if (stall[2] && (perf_stall_q != 32'hFFFF_FFFF))
                perf_stall_q <= perf_stall_q + 32'd1;
            if (flush_q && (perf_flush_q != 32'hFFFF_FFFF))
                perf_flush_q <= perf_flush_q + 32'd1;
        end
    end

    assign bus.perf_stall_cycles_o = perf_stall_q;
    assign bus.perf_flush_cnt_o    = perf_flush_q;
`endif
endmodule
